shift_add_mul_ctrl: RTL and testbench
=====================================

SHIFT_ADD_MUL_CTRL -- requirements
Module: shift_add_mul_ctrl

Interface
REQ-001 Parameter N, default 8, operand width in bits; SHALL be >= 2.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 start  input  1  request to begin a multiply; sampled only when ready=1.
REQ-005 a  input  N  unsigned multiplicand; sampled with start.
REQ-006 b  input  N  unsigned multiplier; sampled with start.
REQ-007 ready  output  1  high only in IDLE; a start is accepted on a rising edge when start=1 and ready=1.
REQ-008 done  output  1  one-cycle pulse; product is valid in that cycle.
REQ-009 product  output  2N  unsigned result a*b, registered.

Function
REQ-010 The block SHALL instantiate exactly one N-bit ripple-carry adder with an (N+1)-bit sum, carry-in tied to 0, and SHALL use it for all additions.
REQ-011 States: IDLE, RUN, DONE, encoded in a registered FSM.
REQ-012 IDLE, on start=1: mcand<=a, lo<=b, hi<=0, cnt<=0, go to RUN.
REQ-013 IDLE, on start=0: hold all state.
REQ-014 Adder inputs in RUN: operand A = hi; operand B = lo[0] ? mcand : 0.
REQ-015 RUN, every edge: the (2N+1)-bit value {sum[N:0], lo} SHALL shift right by 1 (hi<=sum[N:1], lo<={sum[0], lo[N-1:1]}), and cnt SHALL increment.
REQ-016 RUN, when cnt==N-1 at the edge: perform the REQ-015 update and go to DONE.
REQ-017 cnt width SHALL be clog2(N) bits or wider; cnt SHALL NOT wrap within one operation.
REQ-018 DONE: product={hi,lo}, driven registered; done=1 for exactly this one cycle; ready=0; the next edge SHALL go to IDLE.
REQ-019 Latency: accept edge E, RUN for exactly N edges (E+1..E+N), done high in the cycle following edge E+N. Accept-to-done is N+1 cycles.
REQ-020 start while ready=0 (RUN or DONE) SHALL be ignored and SHALL NOT be queued.
REQ-021 a and b changes after the accept edge SHALL NOT affect the result.
REQ-022 product SHALL hold its last value from DONE until the next DONE; it SHALL NOT change during RUN.
REQ-023 Arithmetic is unsigned; the result SHALL be exact for all 2^(2N) operand pairs, with no truncation.
REQ-024 Back-to-back: a start asserted in the IDLE cycle right after DONE SHALL be accepted; the minimum operation period is N+2 cycles.

Reset
REQ-025 rst=1 at an edge SHALL force IDLE, hi=0, lo=0, mcand=0, cnt=0, product=0, done=0. ready SHALL be 1 from the following cycle.
REQ-026 rst SHALL take priority over start and over every FSM transition.
REQ-027 rst asserted during RUN or DONE SHALL abort the operation. No done pulse SHALL follow, and product SHALL read 0.

Verification
REQ-028 N=8, a=13, b=11, start for 1 cycle -> ready=0 for 9 cycles, done pulse 9 cycles after the accept edge, product=143.
REQ-029 N=8, a=255, b=255 -> product=65025 (0xFE01). Checks carry-out propagation every cycle.
REQ-030 a=0, b=200, then a=200, b=0 -> product=0 both times, with done timing identical to REQ-028.
REQ-031 start held high continuously with a=3, b=5 and then a=7, b=9 presented during RUN -> first product=15. The second operation is accepted only in the IDLE cycle after DONE. Verify an N+2-cycle period and no extra done pulses.
REQ-032 rst pulsed at RUN cycle 4 of a=100, b=100 -> no done pulse, product=0, ready=1. A new start with a=2, b=3 then yields product=6.
REQ-033 Random unsigned a,b (>=1000 operations, random start gaps) -> each product equals the a*b reference. done is exactly 1 cycle wide, and product is stable between done pulses.

Source files
------------

// File: rtl/shift_add_mul_ctrl.sv
// Sequential shift-and-add unsigned multiplier.
// One operand bit is retired per RUN cycle through a single ripple-carry
// adder; the product is registered and presented for one DONE cycle.

// N-bit ripple-carry adder, carry-in tied low, (N+1)-bit sum.
module shift_add_mul_rca #(
    parameter int N = 8
) (
    input  logic [N-1:0] op_a_i,
    input  logic [N-1:0] op_b_i,
    output logic [N:0]   sum_o
);
    logic [N:0] carry_s;

    assign carry_s[0] = 1'b0;

    for (genvar i = 0; i < N; i++) begin : g_fa
        assign sum_o[i]       = op_a_i[i] ^ op_b_i[i] ^ carry_s[i];
        assign carry_s[i + 1] = (op_a_i[i] & op_b_i[i]) |
                                (carry_s[i] & (op_a_i[i] ^ op_b_i[i]));
    end

    assign sum_o[N] = carry_s[N];
endmodule

module shift_add_mul_ctrl #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           ready,
    output logic           done,
    output logic [2*N-1:0] product
);
    // One extra counter bit so the final increment never wraps to zero.
    localparam int CW = $clog2(N) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]     state_q,   state_d;
    logic [N-1:0]   mcand_q,   mcand_d;
    logic [N-1:0]   hi_q,      hi_d;
    logic [N-1:0]   lo_q,      lo_d;
    logic [CW-1:0]  cnt_q,     cnt_d;
    logic [2*N-1:0] product_q, product_d;
    logic           ready_q,   ready_d;
    logic           done_q,    done_d;

    logic [N-1:0]   add_b_s;
    logic [N:0]     sum_s;

    // Partial-product select: add the multiplicand only when the current multiplier bit is set.
    always_comb begin
        if (lo_q[0]) begin
            add_b_s = mcand_q;
        end else begin
            add_b_s = {N{1'b0}};
        end
    end

    shift_add_mul_rca #(.N(N)) u_rca (
        .op_a_i (hi_q),
        .op_b_i (add_b_s),
        .sum_o  (sum_s)
    );

    // Next-state logic: accept in IDLE, shift-add in RUN, single DONE cycle.
    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mcand_d = a;
                    lo_d    = b;
                    hi_d    = {N{1'b0}};
                    cnt_d   = {CW{1'b0}};
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                // {sum, lo} shifted right by one: the low sum bit moves into lo.
                hi_d  = sum_s[N:1];
                lo_d  = {sum_s[0], lo_q[N-1:1]};
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) begin
                    product_d = {sum_s, lo_q[N-1:1]};
                    state_d   = S_DONE;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        ready_d = (state_d == S_IDLE);
        done_d  = (state_d == S_DONE);
    end

    // State registers with synchronous reset; ready/done are registered from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            mcand_q   <= {N{1'b0}};
            hi_q      <= {N{1'b0}};
            lo_q      <= {N{1'b0}};
            cnt_q     <= {CW{1'b0}};
            product_q <= {(2*N){1'b0}};
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
            ready_q   <= ready_d;
            done_q    <= done_d;
        end
    end

    assign ready   = ready_q;
    assign done    = done_q;
    assign product = product_q;
endmodule

// File: tb/tb_shift_add_mul_ctrl.sv
// Directed and random checks for shift_add_mul_ctrl at N=8.
module tb_shift_add_mul_ctrl;
    localparam int N = 8;

    logic           clk;
    logic           rst;
    logic           start;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic           ready;
    logic           done;
    logic [2*N-1:0] product;

    int             n_cmp;
    int             n_bad;
    logic [63:0]    prev_prod;

    shift_add_mul_ctrl #(.N(N)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .ready   (ready),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Present operands and start; returns #1 after the accept edge, operands scrambled.
    task automatic start_op(input logic [N-1:0] av, input logic [N-1:0] bv, input bit hold_start);
        check_eq("ready_before_start", {63'd0, ready}, 64'd1);
        start = 1'b1;
        a     = av;
        b     = bv;
        @(posedge clk);
        #1;
        if (!hold_start) begin
            start = 1'b0;
        end
        a = N'($urandom);
        b = N'($urandom);
    endtask

    // Follows edges E+1 .. E+N+1 after an accept edge E.
    task automatic await_result(input logic [63:0] exp);
        for (int j = 1; j <= N + 1; j++) begin
            @(posedge clk);
            #1;
            check_eq("done_timing", {63'd0, done}, (j == N) ? 64'd1 : 64'd0);
            if (j < N) begin
                check_eq("ready_run", {63'd0, ready}, 64'd0);
                check_eq("prod_hold", {48'd0, product}, prev_prod);
            end else if (j == N) begin
                check_eq("ready_done", {63'd0, ready}, 64'd0);
                check_eq("product", {48'd0, product}, exp);
            end else begin
                check_eq("ready_idle", {63'd0, ready}, 64'd1);
                check_eq("prod_keep", {48'd0, product}, exp);
            end
        end
        prev_prod = exp;
    endtask

    initial begin
        logic [N-1:0] ra;
        logic [N-1:0] rb;
        int           gap;
        n_cmp     = 0;
        n_bad     = 0;
        prev_prod = 64'd0;
        rst       = 1'b1;
        start     = 1'b0;
        a         = {N{1'b0}};
        b         = {N{1'b0}};

        // Reset, with start asserted to confirm reset priority.
        @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        rst   = 1'b0;
        check_eq("rst_ready", {63'd0, ready}, 64'd1);
        check_eq("rst_done", {63'd0, done}, 64'd0);
        check_eq("rst_product", {48'd0, product}, 64'd0);

        // Basic, all-ones, and zero operands.
        start_op(8'd13, 8'd11, 1'b0);
        await_result(64'd143);
        start_op(8'd255, 8'd255, 1'b0);
        await_result(64'd65025);
        start_op(8'd0, 8'd200, 1'b0);
        await_result(64'd0);
        start_op(8'd200, 8'd0, 1'b0);
        await_result(64'd0);
        start_op(8'd1, 8'd255, 1'b0);
        await_result(64'd255);
        start_op(8'd128, 8'd2, 1'b0);
        await_result(64'd256);

        // Start held high: second op accepted only after DONE, period N+2.
        start_op(8'd3, 8'd5, 1'b1);
        a = 8'd7;
        b = 8'd9;
        await_result(64'd15);
        @(posedge clk);
        #1;
        start = 1'b0;
        check_eq("b2b_accepted", {63'd0, ready}, 64'd0);
        a = 8'd0;
        b = 8'd0;
        await_result(64'd63);

        // Reset during RUN cycle 4 aborts the operation.
        start_op(8'd100, 8'd100, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check_eq("abort_in_run", {63'd0, ready}, 64'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_eq("abort_ready", {63'd0, ready}, 64'd1);
        check_eq("abort_product", {48'd0, product}, 64'd0);
        check_eq("abort_done", {63'd0, done}, 64'd0);
        for (int k = 0; k < N + 2; k++) begin
            @(posedge clk);
            #1;
            check_eq("abort_no_done", {63'd0, done}, 64'd0);
        end
        prev_prod = 64'd0;
        start_op(8'd2, 8'd3, 1'b0);
        await_result(64'd6);

        // Random operands with random idle gaps (gap 0 is back-to-back).
        repeat (1000) begin
            gap = $urandom_range(0, 3);
            for (int k = 0; k < gap; k++) begin
                @(posedge clk);
                #1;
                check_eq("gap_no_done", {63'd0, done}, 64'd0);
            end
            ra = N'($urandom);
            rb = N'($urandom);
            start_op(ra, rb, 1'b0);
            await_result(64'(ra) * 64'(rb));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
